// File: rtl/idex_issue_ctrl_pkg.sv
// Shared types and sizes for the ID/EX issue controller.
// Holds the FSM encoding, scoreboard geometry and a saturating-increment helper.
package idex_issue_ctrl_pkg;

    localparam int REG_IDX_W   = 5;
    localparam int NUM_REGS    = 32;
    localparam int PEND_W      = 2;
    localparam int STALL_CNT_W = 16;

    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_STALL = 2'd2
    } state_t;

    function automatic logic [STALL_CNT_W-1:0] sat_inc(
        input logic [STALL_CNT_W-1:0] v
    );
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/idex_issue_ctrl_pend_scoreboard.sv
// Per-register pending-write counters with writeback-forwarded lookups.
// Entry 0 never leaves zero; a same-cycle inc and dec cancel out.
module pend_scoreboard
    import idex_issue_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [REG_IDX_W-1:0] rs1,
    input  logic [REG_IDX_W-1:0] rs2,
    input  logic [REG_IDX_W-1:0] rd,
    input  logic                 inc_en,
    input  logic [REG_IDX_W-1:0] inc_idx,
    input  logic                 wb_valid,
    input  logic [REG_IDX_W-1:0] wb_rd,
    output logic [PEND_W-1:0]    eff_rs1,
    output logic [PEND_W-1:0]    eff_rs2,
    output logic [PEND_W-1:0]    eff_rd,
    output logic                 underflow
);

    logic [NUM_REGS-1:0][PEND_W-1:0] pend;
    logic [NUM_REGS-1:0]             inc_vec;
    logic [NUM_REGS-1:0]             dec_vec;
    logic                            wb_live;

    assign wb_live = wb_valid && (wb_rd != '0);

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        if (inc_en && (inc_idx != '0))
            inc_vec[inc_idx] = 1'b1;
        if (wb_live && (pend[wb_rd] != '0))
            dec_vec[wb_rd] = 1'b1;
    end

    // Retiring writes are visible to the reader in the same cycle.
    assign eff_rs1 = dec_vec[rs1] ? pend[rs1] - 1'b1 : pend[rs1];
    assign eff_rs2 = dec_vec[rs2] ? pend[rs2] - 1'b1 : pend[rs2];
    assign eff_rd  = dec_vec[rd]  ? pend[rd]  - 1'b1 : pend[rd];

    assign underflow = wb_live && (pend[wb_rd] == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            pend <= '0;
        end else begin
            for (int r = 1; r < NUM_REGS; r++) begin
                if (inc_vec[r] && !dec_vec[r])
                    pend[r] <= pend[r] + 1'b1;
                else if (dec_vec[r] && !inc_vec[r])
                    pend[r] <= pend[r] - 1'b1;
            end
        end
    end

endmodule

// File: rtl/idex_issue_ctrl.sv
// Decode-to-execute issue control: RAW/overflow hazard detection,
// stall FSM, saturating stall counter and sticky underflow flag.
module idex_issue_ctrl
    import idex_issue_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   id_valid,
    input  logic [REG_IDX_W-1:0]   id_rs1,
    input  logic [REG_IDX_W-1:0]   id_rs2,
    input  logic                   id_use_rs1,
    input  logic                   id_use_rs2,
    input  logic                   id_reg_write,
    input  logic [REG_IDX_W-1:0]   id_rd,
    input  logic                   wb_valid,
    input  logic [REG_IDX_W-1:0]   wb_rd,
    input  logic                   flush,
    output logic                   issue,
    output logic                   id_stall,
    output logic                   idex_bubble,
    output logic [1:0]             state,
    output logic [STALL_CNT_W-1:0] stall_count,
    output logic                   err_underflow
);

    state_t            st, st_nxt;
    logic [PEND_W-1:0] eff_rs1, eff_rs2, eff_rd;
    logic              underflow;
    logic              hazard;
    logic              active;
    logic              haz_rs1, haz_rs2, haz_rd;

    pend_scoreboard u_sb (
        .clk       (clk),
        .reset     (reset),
        .rs1       (id_rs1),
        .rs2       (id_rs2),
        .rd        (id_rd),
        .inc_en    (issue && id_reg_write),
        .inc_idx   (id_rd),
        .wb_valid  (wb_valid),
        .wb_rd     (wb_rd),
        .eff_rs1   (eff_rs1),
        .eff_rs2   (eff_rs2),
        .eff_rd    (eff_rd),
        .underflow (underflow)
    );

    assign haz_rs1 = id_use_rs1 && (id_rs1 != '0) && (eff_rs1 != '0);
    assign haz_rs2 = id_use_rs2 && (id_rs2 != '0) && (eff_rs2 != '0);
    // A full counter cannot absorb another outstanding write.
    assign haz_rd  = id_reg_write && (id_rd != '0) && (eff_rd == PEND_MAX);
    assign hazard  = id_valid && (haz_rs1 || haz_rs2 || haz_rd);

    assign active      = (st != S_IDLE);
    assign issue       = id_valid && !hazard && !flush && active;
    assign id_stall    = id_valid && hazard && !flush && active;
    assign idex_bubble = !issue;
    assign state       = st;

    always_comb begin
        st_nxt = st;
        unique case (st)
            S_IDLE:  st_nxt = S_RUN;
            S_RUN:   st_nxt = id_stall ? S_STALL : S_RUN;
            S_STALL: st_nxt = id_stall ? S_STALL : S_RUN;
            default: st_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st            <= S_IDLE;
            stall_count   <= '0;
            err_underflow <= 1'b0;
        end else begin
            st <= st_nxt;
            if (id_stall)
                stall_count <= sat_inc(stall_count);
            if (underflow)
                err_underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_idex_issue_ctrl.sv
// Directed self-checking bench for idex_issue_ctrl.
// Expected values are hand-derived per step.
module tb_idex_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [4:0]  id_rs1, id_rs2, id_rd, wb_rd;
    logic        id_use_rs1, id_use_rs2, id_reg_write;
    logic        wb_valid, flush;
    logic        issue, id_stall, idex_bubble, err_underflow;
    logic [1:0]  state;
    logic [15:0] stall_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    idex_issue_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .id_valid      (id_valid),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_use_rs1    (id_use_rs1),
        .id_use_rs2    (id_use_rs2),
        .id_reg_write  (id_reg_write),
        .id_rd         (id_rd),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .flush         (flush),
        .issue         (issue),
        .id_stall      (id_stall),
        .idex_bubble   (idex_bubble),
        .state         (state),
        .stall_count   (stall_count),
        .err_underflow (err_underflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic u1, input logic [4:0] r1,
                         input logic u2, input logic [4:0] r2,
                         input logic rw, input logic [4:0] rd,
                         input logic wv, input logic [4:0] wr,
                         input logic fl);
        id_valid     = v;
        id_use_rs1   = u1;
        id_rs1       = r1;
        id_use_rs2   = u2;
        id_rs2       = r2;
        id_reg_write = rw;
        id_rd        = rd;
        wb_valid     = wv;
        wb_rd        = wr;
        flush        = fl;
        #1;
    endtask

    task automatic comb3(input string tag, input logic i, input logic s);
        chk({tag, ".issue"}, issue, i);
        chk({tag, ".stall"}, id_stall, s);
        chk({tag, ".bubble"}, idex_bubble, !i);
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        chk("rst.state", state, 0);
        chk("rst.cnt", stall_count, 0);
        chk("rst.err", err_underflow, 0);
        comb3("rst", 0, 0);

        // Reset release: first cycle IDLE, issue from the second.
        reset = 1'b0;
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        comb3("idle", 0, 0);
        chk("idle.state", state, 0);
        tick();
        chk("run.state", state, 1);
        comb3("run", 1, 0);

        // RAW on x5, resolved by a later writeback.
        drive(1, 0, 0, 0, 0, 1, 5, 0, 0, 0);
        comb3("raw.prod", 1, 0);
        tick();
        drive(1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
        comb3("raw.dep", 0, 1);
        tick();
        chk("raw.state", state, 2);
        chk("raw.cnt", stall_count, 1);
        drive(1, 1, 5, 0, 0, 0, 0, 1, 5, 0);
        comb3("raw.wb", 1, 0);
        tick();
        chk("raw.back", state, 1);
        chk("raw.cnt2", stall_count, 1);
        drive(1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
        comb3("raw.clear", 1, 0);

        // Writeback arrives in the would-be first stall cycle.
        drive(1, 0, 0, 0, 0, 1, 5, 0, 0, 0);
        comb3("var.prod", 1, 0);
        tick();
        drive(1, 1, 5, 0, 0, 0, 0, 1, 5, 0);
        comb3("var.dep", 1, 0);
        tick();
        chk("var.state", state, 1);
        chk("var.cnt", stall_count, 1);

        // Three outstanding writes to x7 fill the counter.
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 0, 0, 0, 1, 7, 0, 0, 0);
            comb3("full.fill", 1, 0);
            tick();
        end
        drive(1, 0, 0, 0, 0, 1, 7, 0, 0, 0);
        comb3("full.4th", 0, 1);
        tick();
        chk("full.state", state, 2);
        chk("full.cnt", stall_count, 2);
        drive(1, 0, 0, 0, 0, 1, 7, 1, 7, 0);
        comb3("full.wb", 1, 0);
        tick();
        chk("full.back", state, 1);
        drive(1, 0, 0, 0, 0, 1, 7, 0, 0, 0);
        comb3("full.still3", 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 7, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("full.drain.err", err_underflow, 0);
        end

        // x0 never stalls and never sets the error.
        for (int k = 0; k < 4; k++) begin
            drive(1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
            comb3("x0.rd", 1, 0);
            tick();
        end
        drive(1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
        comb3("x0.rs", 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        tick();
        chk("x0.err", err_underflow, 0);

        // Flush beats a hazard and blocks the increment.
        drive(1, 0, 0, 0, 0, 1, 9, 0, 0, 0);
        comb3("fl.prod", 1, 0);
        tick();
        drive(1, 1, 9, 0, 0, 1, 10, 0, 0, 1);
        comb3("fl.flush", 0, 0);
        tick();
        chk("fl.cnt", stall_count, 2);
        chk("fl.state", state, 1);
        drive(1, 1, 10, 0, 0, 0, 0, 0, 0, 0);
        comb3("fl.noinc", 1, 0);
        drive(1, 0, 0, 1, 9, 0, 0, 0, 0, 0);
        comb3("fl.rs2haz", 0, 1);

        // Underflow on x9 is sticky.
        drive(0, 0, 0, 0, 0, 0, 0, 1, 9, 0);
        tick();
        chk("uf.legal", err_underflow, 0);
        tick();
        chk("uf.set", err_underflow, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        chk("uf.sticky", err_underflow, 1);

        // Long stall saturates the counter; reset discards everything.
        drive(1, 0, 0, 0, 0, 1, 12, 0, 0, 0);
        comb3("sat.prod", 1, 0);
        tick();
        drive(1, 1, 12, 0, 0, 0, 0, 0, 0, 0);
        comb3("sat.dep", 0, 1);
        repeat (70000) tick();
        chk("sat.cnt", stall_count, 16'hFFFF);
        chk("sat.state", state, 2);
        chk("sat.stall", id_stall, 1);
        reset = 1'b1;
        tick();
        chk("sat.rst.state", state, 0);
        chk("sat.rst.cnt", stall_count, 0);
        chk("sat.rst.err", err_underflow, 0);
        reset = 1'b0;
        #1;
        comb3("post.idle", 0, 0);
        tick();
        chk("post.state", state, 1);
        comb3("post.run", 1, 0);
        tick();
        chk("post.cnt", stall_count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
